// File: rtl/delay_mem_pkg.sv
// delay_mem_pkg
// Shared definitions for the delay-memory controller: the controller state
// encodings and the address-width helper that the delay-buffer manager also
// uses, so both sides always agree on the address bus width.
package delay_mem_pkg;

    localparam logic [2:0] ST_CLEAR    = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_READ     = 3'd3;
    localparam logic [2:0] ST_COOLDOWN = 3'd4;

    typedef enum logic [2:0] {
        CLEAR    = ST_CLEAR,
        IDLE     = ST_IDLE,
        WRITE    = ST_WRITE,
        READ     = ST_READ,
        COOLDOWN = ST_COOLDOWN
    } state_t;

    // Address bits needed for a memory of the given number of words. A
    // single-word memory still gets a one-bit address so no port collapses
    // to zero width.
    function automatic int calc_addr_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/delay_mem_ctrl_if.sv
// delay_mem_ctrl_if
// Request/response bundle between the delay-buffer manager (master) and the
// delay-memory controller (slave).
//   rd_req/rd_addr      read request, held until rd_valid
//   rd_data/rd_valid    signed read result with its one-cycle strobe
//   wr_req/wr_addr/wr_data  write request, held until wr_ack
//   wr_ack              one-cycle write-committed strobe
//   clear_req           restart the zero-fill (only honoured while idle)
//   ready               memory has been zero-filled
//   oob_access          one-cycle strobe, the finished access was out of range
interface delay_mem_ctrl_if
    import delay_mem_pkg::*;
#(
    parameter int data_width = 16,
    parameter int addr_width = calc_addr_width(8192)
);

    logic                         rd_req;
    logic [addr_width-1:0]        rd_addr;
    logic signed [data_width-1:0] rd_data;
    logic                         rd_valid;
    logic                         wr_req;
    logic [addr_width-1:0]        wr_addr;
    logic signed [data_width-1:0] wr_data;
    logic                         wr_ack;
    logic                         clear_req;
    logic                         ready;
    logic                         oob_access;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, clear_req,
        input  rd_data, rd_valid, wr_ack, ready, oob_access
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, clear_req,
        output rd_data, rd_valid, wr_ack, ready, oob_access
    );

endinterface

// File: rtl/delay_mem_ctrl.sv
// delay_mem_ctrl
// Turns the delay-buffer manager's level-held read/write requests into a
// single-port synchronous SRAM access sequence and answers with one-cycle
// rd_valid / wr_ack strobes. After reset (or a clear request) it zero-fills
// every SRAM word so freshly allocated delay lines play silence.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   bus             delay_mem_ctrl_if slave side (requests, results, ready)
//   sram_en/sram_we SRAM enable and write enable
//   sram_addr       SRAM word address
//   sram_wdata      SRAM write data
//   sram_rdata      SRAM read data, valid read_latency cycles after the enable
module delay_mem_ctrl
    import delay_mem_pkg::*;
#(
    parameter  int data_width   = 16,
    parameter  int memory_size  = 8192,
    parameter  int read_latency = 2,
    localparam int addr_width   = calc_addr_width(memory_size)
) (
    input  logic                  clk,
    input  logic                  reset,
    delay_mem_ctrl_if.slave       bus,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [addr_width-1:0] sram_addr,
    output logic [data_width-1:0] sram_wdata,
    input  logic [data_width-1:0] sram_rdata
);

    localparam int lat_width = $clog2(read_latency + 1);
    localparam logic [addr_width-1:0] last_addr = addr_width'(memory_size - 1);
    localparam logic [addr_width:0]   mem_limit = (addr_width + 1)'(memory_size);

    state_t                       state;
    state_t                       state_next;
    logic [addr_width-1:0]        clr_cnt;
    logic [addr_width-1:0]        clr_cnt_next;
    logic [lat_width-1:0]         lat_cnt;
    logic [lat_width-1:0]         lat_cnt_next;
    logic                         oob_pend;
    logic                         oob_pend_next;
    logic                         ready_q;
    logic                         ready_next;
    logic signed [data_width-1:0] rd_data_q;
    logic signed [data_width-1:0] rd_data_next;
    logic                         rd_valid_q;
    logic                         rd_valid_next;
    logic                         wr_ack_q;
    logic                         wr_ack_next;
    logic                         oob_access_q;
    logic                         oob_access_next;
    logic                         sram_en_next;
    logic                         sram_we_next;
    logic [addr_width-1:0]        sram_addr_next;
    logic [data_width-1:0]        sram_wdata_next;
    logic                         wr_oob;
    logic                         rd_oob;

    // Addresses past the end of the memory are only reachable when the size
    // is not a power of two; such accesses must never strobe the SRAM.
    assign wr_oob = ({1'b0, bus.wr_addr} >= mem_limit);
    assign rd_oob = ({1'b0, bus.rd_addr} >= mem_limit);

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.ready      = ready_q;
    assign bus.oob_access = oob_access_q;

    // Next-state and next-output logic. Strobes and pulses default to zero
    // so every state only has to say what it turns on; addresses, data and
    // the ready flag hold unless a state changes them.
    always_comb begin
        state_next      = state;
        clr_cnt_next    = clr_cnt;
        lat_cnt_next    = lat_cnt;
        oob_pend_next   = oob_pend;
        ready_next      = ready_q;
        rd_data_next    = rd_data_q;
        rd_valid_next   = 1'b0;
        wr_ack_next     = 1'b0;
        oob_access_next = 1'b0;
        sram_en_next    = 1'b0;
        sram_we_next    = 1'b0;
        sram_addr_next  = sram_addr;
        sram_wdata_next = sram_wdata;

        case (state)
            CLEAR: begin
                sram_en_next    = 1'b1;
                sram_we_next    = 1'b1;
                sram_addr_next  = clr_cnt;
                sram_wdata_next = '0;
                if (clr_cnt == last_addr) begin
                    clr_cnt_next = '0;
                    ready_next   = 1'b1;
                    state_next   = IDLE;
                end else begin
                    clr_cnt_next = clr_cnt + addr_width'(1);
                end
            end

            IDLE: begin
                if (bus.clear_req) begin
                    ready_next   = 1'b0;
                    clr_cnt_next = '0;
                    state_next   = CLEAR;
                end else if (bus.wr_req) begin
                    oob_pend_next   = wr_oob;
                    sram_en_next    = !wr_oob;
                    sram_we_next    = !wr_oob;
                    sram_addr_next  = bus.wr_addr;
                    sram_wdata_next = bus.wr_data;
                    state_next      = WRITE;
                end else if (bus.rd_req) begin
                    oob_pend_next  = rd_oob;
                    sram_en_next   = !rd_oob;
                    sram_addr_next = bus.rd_addr;
                    lat_cnt_next   = lat_width'(read_latency);
                    state_next     = READ;
                end
            end

            WRITE: begin
                wr_ack_next     = 1'b1;
                oob_access_next = oob_pend;
                state_next      = COOLDOWN;
            end

            READ: begin
                if (lat_cnt == '0) begin
                    rd_data_next    = oob_pend ? '0 : $signed(sram_rdata);
                    rd_valid_next   = 1'b1;
                    oob_access_next = oob_pend;
                    state_next      = COOLDOWN;
                end else begin
                    lat_cnt_next = lat_cnt - lat_width'(1);
                end
            end

            // The manager drops its request one edge after it sees the
            // ack, so whatever is sampled here is stale and is skipped.
            COOLDOWN: begin
                state_next = IDLE;
            end

            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    // All state and outputs are registered. Reset aborts whatever is in
    // flight, cancels pending strobes and restarts the zero-fill at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            lat_cnt      <= '0;
            oob_pend     <= 1'b0;
            ready_q      <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_ack_q     <= 1'b0;
            oob_access_q <= 1'b0;
            sram_en      <= 1'b0;
            sram_we      <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= '0;
        end else begin
            state        <= state_next;
            clr_cnt      <= clr_cnt_next;
            lat_cnt      <= lat_cnt_next;
            oob_pend     <= oob_pend_next;
            ready_q      <= ready_next;
            rd_data_q    <= rd_data_next;
            rd_valid_q   <= rd_valid_next;
            wr_ack_q     <= wr_ack_next;
            oob_access_q <= oob_access_next;
            sram_en      <= sram_en_next;
            sram_we      <= sram_we_next;
            sram_addr    <= sram_addr_next;
            sram_wdata   <= sram_wdata_next;
        end
    end

endmodule

// File: tb/tb_delay_mem_ctrl.sv
// Behavioural single-port SRAM used only by the bench. Every word powers up
// as 0xA5A5 so a word the zero-fill missed stands out. Read data appears
// read_latency edges after the edge that samples the enable.
module delay_sram #(
    parameter int data_width   = 16,
    parameter int memory_size  = 16,
    parameter int read_latency = 2,
    parameter int addr_width   = 4
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wdata,
    output logic [data_width-1:0] rdata
);

    logic [data_width-1:0] mem  [memory_size];
    logic [data_width-1:0] pipe [read_latency];

    // Power-up pattern.
    initial begin
        for (int i = 0; i < memory_size; i++) mem[i] <= data_width'(16'hA5A5);
        for (int i = 0; i < read_latency; i++) pipe[i] <= data_width'(16'hA5A5);
    end

    // Write port plus a read pipeline read_latency stages deep.
    always @(posedge clk) begin
        if (en && we && int'(addr) < memory_size) mem[addr] <= wdata;
        if (en && !we && int'(addr) < memory_size) pipe[0] <= mem[addr];
        for (int i = 1; i < read_latency; i++) pipe[i] <= pipe[i-1];
    end

    assign rdata = pipe[read_latency-1];

endmodule

// Bench for delay_mem_ctrl. Two instances share the clock: dut_a with a
// 16-word memory carries most of the traffic, dut_b with a 12-word memory
// exercises out-of-range addresses. Stimulus pushes the expected response
// (kind, cycle, data, oob flag) into a per-instance queue; monitors pop and
// compare whenever a DUT raises rd_valid or wr_ack.
module tb_delay_mem_ctrl;

    localparam int LAT = 2;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        bit          oob;
        int          due;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset_a;
    logic        reset_b;
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    int          valid_cnt_a = 0;
    int          en_cnt_b = 0;
    int          ready_at_a;
    int          ready_at_b;
    int          nonzero;
    int          snap;
    int          n;
    exp_t        exp_a[$];
    exp_t        exp_b[$];
    exp_t        e;

    logic        sram_en_a, sram_we_a, sram_en_b, sram_we_b;
    logic [3:0]  sram_addr_a, sram_addr_b;
    logic [15:0] sram_wdata_a, sram_rdata_a, sram_wdata_b, sram_rdata_b;

    delay_mem_ctrl_if #(.data_width(16), .addr_width(4)) ifa ();
    delay_mem_ctrl_if #(.data_width(16), .addr_width(4)) ifb ();

    delay_mem_ctrl #(.data_width(16), .memory_size(16), .read_latency(LAT)) dut_a (
        .clk(clk), .reset(reset_a), .bus(ifa),
        .sram_en(sram_en_a), .sram_we(sram_we_a), .sram_addr(sram_addr_a),
        .sram_wdata(sram_wdata_a), .sram_rdata(sram_rdata_a)
    );

    delay_mem_ctrl #(.data_width(16), .memory_size(12), .read_latency(LAT)) dut_b (
        .clk(clk), .reset(reset_b), .bus(ifb),
        .sram_en(sram_en_b), .sram_we(sram_we_b), .sram_addr(sram_addr_b),
        .sram_wdata(sram_wdata_b), .sram_rdata(sram_rdata_b)
    );

    delay_sram #(.data_width(16), .memory_size(16), .read_latency(LAT), .addr_width(4)) sram_a (
        .clk(clk), .en(sram_en_a), .we(sram_we_a), .addr(sram_addr_a),
        .wdata(sram_wdata_a), .rdata(sram_rdata_a)
    );

    delay_sram #(.data_width(16), .memory_size(12), .read_latency(LAT), .addr_width(4)) sram_b (
        .clk(clk), .en(sram_en_b), .we(sram_we_b), .addr(sram_addr_b),
        .wdata(sram_wdata_b), .rdata(sram_rdata_b)
    );

    // Clock and edge counter; cyc is the index of the most recent edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Counts SRAM enables on the 12-word instance.
    always @(posedge clk) if (sram_en_b) en_cnt_b++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Pops the next expected response for one instance and compares it.
    task automatic checkResp(input bit sel, input logic valid, input logic ack,
                             input logic [15:0] data, input logic oob);
        exp_t x;
        if ((sel ? exp_b.size() : exp_a.size()) == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_pulse dut%0d at cycle %0d: rd_valid=%0b wr_ack=%0b, expected none",
                     sel, cyc, valid, ack);
            return;
        end
        if (sel) x = exp_b.pop_front();
        else     x = exp_a.pop_front();
        checkOutput({x.name, "_kind"},   32'(valid), 32'(x.is_read));
        checkOutput({x.name, "_single"}, 32'(valid & ack), 32'd0);
        checkOutput({x.name, "_cycle"},  32'(cyc), 32'(x.due));
        if (x.is_read) checkOutput({x.name, "_data"}, 32'(data), 32'(x.data));
        checkOutput({x.name, "_oob"},    32'(oob), 32'(x.oob));
    endtask

    // Monitors, sampling 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ifa.rd_valid) valid_cnt_a++;
        if (ifa.rd_valid || ifa.wr_ack)
            checkResp(1'b0, ifa.rd_valid, ifa.wr_ack, ifa.rd_data, ifa.oob_access);
    end

    always @(posedge clk) begin
        #1;
        if (ifb.rd_valid || ifb.wr_ack)
            checkResp(1'b1, ifb.rd_valid, ifb.wr_ack, ifb.rd_data, ifb.oob_access);
    end

    task automatic setReq(input bit sel, input bit is_read, input bit on,
                          input logic [3:0] addr, input logic [15:0] data);
        if (sel) begin
            if (is_read) begin ifb.rd_req = on; ifb.rd_addr = addr; end
            else begin ifb.wr_req = on; ifb.wr_addr = addr; ifb.wr_data = data; end
        end else begin
            if (is_read) begin ifa.rd_req = on; ifa.rd_addr = addr; end
            else begin ifa.wr_req = on; ifa.wr_addr = addr; ifa.wr_data = data; end
        end
    endtask

    task automatic pushExp(input bit sel, input bit is_read, input logic [15:0] data,
                           input bit oob, input int due, input string name);
        exp_t x;
        x.is_read = is_read;
        x.data    = data;
        x.oob     = oob;
        x.due     = due;
        x.name    = name;
        if (sel) exp_b.push_back(x);
        else     exp_a.push_back(x);
    endtask

    // Waits (bounded) for the ack/valid, then keeps the request up for one
    // more edge the way the manager does before dropping it.
    task automatic waitFor(input bit sel, input bit is_read, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (sel) seen = is_read ? ifb.rd_valid : ifb.wr_ack;
            else     seen = is_read ? ifa.rd_valid : ifa.wr_ack;
        end
        if (!seen) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s_timeout: no response in 60 cycles, expected one", name);
        end
        @(posedge clk);
        #1;
        setReq(sel, is_read, 1'b0, 4'd0, 16'd0);
    endtask

    // Single access issued while the controller is idle: sampled on the
    // next edge, ack one edge later, read data LAT edges after that.
    task automatic applyStimulus(input bit sel, input bit is_read, input logic [3:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] exp_data,
                                 input bit exp_oob, input string name);
        pushExp(sel, is_read, exp_data, exp_oob, cyc + (is_read ? 2 + LAT : 2), name);
        setReq(sel, is_read, 1'b1, addr, wdata);
        waitFor(sel, is_read, name);
    endtask

    // Hard stop if something hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        ifa.rd_req = 0; ifa.rd_addr = 0; ifa.wr_req = 0; ifa.wr_addr = 0; ifa.wr_data = 0; ifa.clear_req = 0;
        ifb.rd_req = 0; ifb.rd_addr = 0; ifb.wr_req = 0; ifb.wr_addr = 0; ifb.wr_data = 0; ifb.clear_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        checkOutput("rst_rd_valid",   32'(ifa.rd_valid), 32'd0);
        checkOutput("rst_wr_ack",     32'(ifa.wr_ack), 32'd0);
        checkOutput("rst_ready",      32'(ifa.ready), 32'd0);
        checkOutput("rst_oob",        32'(ifa.oob_access), 32'd0);
        checkOutput("rst_rd_data",    32'(ifa.rd_data), 32'd0);
        checkOutput("rst_sram_en",    32'(sram_en_a), 32'd0);
        checkOutput("rst_sram_we",    32'(sram_we_a), 32'd0);
        checkOutput("rst_sram_addr",  32'(sram_addr_a), 32'd0);
        checkOutput("rst_sram_wdata", 32'(sram_wdata_a), 32'd0);

        // Zero-fill timing: ready follows memory_size edges after release.
        reset_a = 1'b0;
        reset_b = 1'b0;
        ready_at_a = -1;
        ready_at_b = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (ready_at_a < 0 && ifa.ready) ready_at_a = i;
            if (ready_at_b < 0 && ifb.ready) ready_at_b = i;
        end
        checkOutput("ready_rise_a", 32'(ready_at_a), 32'd16);
        checkOutput("ready_rise_b", 32'(ready_at_b), 32'd12);
        nonzero = 0;
        for (int i = 0; i < 16; i++) if (sram_a.mem[i] != 16'h0000) nonzero++;
        for (int i = 0; i < 12; i++) if (sram_b.mem[i] != 16'h0000) nonzero++;
        checkOutput("zero_fill_words", 32'(nonzero), 32'd0);

        // Basic accesses, including the signed extremes.
        applyStimulus(0, 1, 4'd9,  16'h0000, 16'h0000, 0, "rd_fresh9");
        applyStimulus(0, 0, 4'd5,  16'h1234, 16'h0000, 0, "wr5");
        applyStimulus(0, 1, 4'd5,  16'h0000, 16'h1234, 0, "rd5");
        applyStimulus(0, 0, 4'd15, 16'h8000, 16'h0000, 0, "wr15");
        applyStimulus(0, 1, 4'd15, 16'h0000, 16'h8000, 0, "rd15");

        // Write and read raised together: write first, read after cooldown.
        n = cyc;
        pushExp(0, 0, 16'h0000, 0, n + 2, "both_wr7");
        pushExp(0, 1, 16'h7FFF, 0, n + 5 + LAT, "both_rd7");
        setReq(0, 0, 1'b1, 4'd7, 16'h7FFF);
        setReq(0, 1, 1'b1, 4'd7, 16'h0000);
        waitFor(0, 0, "both_wr7");
        waitFor(0, 1, "both_rd7");

        // Requests held across a clear: served once each after ready.
        n = cyc;
        ifa.clear_req = 1'b1;
        @(posedge clk);
        #1;
        ifa.clear_req = 1'b0;
        checkOutput("clear_ready_low", 32'(ifa.ready), 32'd0);
        pushExp(0, 0, 16'h0000, 0, n + 19, "held_wr3");
        pushExp(0, 1, 16'h0BEE, 0, n + 22 + LAT, "held_rd3");
        setReq(0, 0, 1'b1, 4'd3, 16'h0BEE);
        setReq(0, 1, 1'b1, 4'd3, 16'h0000);
        waitFor(0, 0, "held_wr3");
        waitFor(0, 1, "held_rd3");
        applyStimulus(0, 1, 4'd5, 16'h0000, 16'h0000, 0, "rd5_cleared");

        // Out-of-range accesses on the 12-word instance.
        applyStimulus(1, 0, 4'd2,  16'h2222, 16'h0000, 0, "b_wr2");
        applyStimulus(1, 1, 4'd2,  16'h0000, 16'h2222, 0, "b_rd2");
        snap = en_cnt_b;
        applyStimulus(1, 0, 4'd13, 16'h5555, 16'h0000, 1, "b_wr13_oob");
        applyStimulus(1, 1, 4'd13, 16'h0000, 16'h0000, 1, "b_rd13_oob");
        checkOutput("b_oob_no_strobe", 32'(en_cnt_b), 32'(snap));
        applyStimulus(1, 1, 4'd1,  16'h0000, 16'h0000, 0, "b_rd1");

        // Reset while a read waits with lat_cnt at 1.
        applyStimulus(0, 0, 4'd0, 16'hFFFF, 16'h0000, 0, "wr0");
        applyStimulus(0, 1, 4'd0, 16'h0000, 16'hFFFF, 0, "rd0");
        snap = valid_cnt_a;
        setReq(0, 1, 1'b1, 4'd0, 16'h0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_a = 1'b1;
        setReq(0, 1, 1'b0, 4'd0, 16'h0000);
        @(posedge clk);
        #1;
        checkOutput("abort_rd_data",  32'(ifa.rd_data), 32'd0);
        checkOutput("abort_sram_en",  32'(sram_en_a), 32'd0);
        reset_a = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("restart_sram_en",   32'(sram_en_a), 32'd1);
        checkOutput("restart_sram_we",   32'(sram_we_a), 32'd1);
        checkOutput("restart_sram_addr", 32'(sram_addr_a), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("restart_sram_addr1", 32'(sram_addr_a), 32'd1);
        for (int i = 0; i < 40 && !ifa.ready; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("abort_ready", 32'(ifa.ready), 32'd1);
        checkOutput("abort_no_valid", 32'(valid_cnt_a), 32'(snap));
        applyStimulus(0, 1, 4'd0, 16'h0000, 16'h0000, 0, "rd0_after_abort");

        // Nothing may be left outstanding.
        repeat (4) @(posedge clk);
        #1;
        checkOutput("pending_a", 32'(exp_a.size()), 32'd0);
        checkOutput("pending_b", 32'(exp_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
